// File: rtl/pipe_ctrl_unit_if.sv
// Request/response bundle between the pipeline stages and the pipeline control unit.
// The control unit takes the slave side; whoever drives stall requests and exceptions is the master.
interface pipe_ctrl_unit_if #(
    parameter int STALL_W = 6,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32
);
    logic [STALL_W-1:0] stallreq;
    logic               excp_req;
    logic [PC_W-1:0]    excp_pc;
    logic               clr_cnt;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [PC_W-1:0]    new_pc;
    logic [CNT_W-1:0]   stall_cycles;
    logic               stall_timeout;

    modport master (
        output stallreq, excp_req, excp_pc, clr_cnt,
        input  stall, flush, new_pc, stall_cycles, stall_timeout
    );

    modport slave (
        input  stallreq, excp_req, excp_pc, clr_cnt,
        output stall, flush, new_pc, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: prefix stall mask, registered one-cycle flush with redirect PC,
// saturating stall-cycle counter and sticky stall watchdog.
module pipe_ctrl_unit #(
    parameter int STALL_W = 6,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_unit_if.slave bus
);

    localparam int RUN_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state;
    state_t             state_next;
    logic [STALL_W-1:0] mask;
    logic               stall_active;
    logic [PC_W-1:0]    new_pc_q;
    logic [CNT_W-1:0]   stall_cycles_q;
    logic [RUN_W-1:0]   run_cnt;
    logic               stall_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // An exception raised during FLUSH belongs to a squashed instruction, so only RUN honours it.
    always_comb begin
        state_next = RUN;
        if (state == RUN && bus.excp_req) begin
            state_next = FLUSH;
        end
    end

    // Stage k stalling holds every earlier stage too: each bit is the OR of itself and all later requests.
    always_comb begin
        mask = '0;
        mask[STALL_W-1] = bus.stallreq[STALL_W-1];
        for (int i = STALL_W - 2; i >= 0; i--) begin
            mask[i] = mask[i+1] | bus.stallreq[i];
        end
    end

    always_comb begin
        bus.stall = mask;
        bus.flush = 1'b0;
        if (rst || state == FLUSH) begin
            bus.stall = '0;
        end
        if (state == FLUSH) begin
            bus.flush = 1'b1;
        end
    end

    assign stall_active = |bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_q <= '0;
        end else if (state == RUN && bus.excp_req) begin
            new_pc_q <= bus.excp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            stall_cycles_q <= '0;
        end else if (stall_active && stall_cycles_q != '1) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    // Run counter tracks the current unbroken stall run; the flag latches on the TIMEOUT-th stalled edge.
    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            run_cnt         <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            if (!stall_active) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
            if (TIMEOUT != 0 && stall_active && run_cnt == RUN_LAST) begin
                stall_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.new_pc        = new_pc_q;
    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit: default instance plus a CNT_W=4 instance for saturation.
module tb_pipe_ctrl_unit;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    pipe_ctrl_unit_if #(.STALL_W(6), .PC_W(32), .CNT_W(32)) bus ();
    pipe_ctrl_unit_if #(.STALL_W(6), .PC_W(32), .CNT_W(4))  bus_s ();

    pipe_ctrl_unit #(.STALL_W(6), .PC_W(32), .CNT_W(32), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_ctrl_unit #(.STALL_W(6), .PC_W(32), .CNT_W(4), .TIMEOUT(64)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; registered outputs are read there too.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stallreq = 6'b001000;
        bus.excp_req = 1'b0;
        bus.excp_pc = '0;
        bus.clr_cnt = 1'b0;
        bus_s.stallreq = '0;
        bus_s.excp_req = 1'b0;
        bus_s.excp_pc = '0;
        bus_s.clr_cnt = 1'b0;
        next_cycle();
        next_cycle();
        tests_run++;
        if (bus.stall !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL reset_stall_forced: got %b expected 000000", bus.stall);
        end
        rst = 1'b0;
        bus.stallreq = '0;
        #1;
        tests_run++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0 || bus.stall_cycles !== 32'd0 || bus.stall_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got flush=%b new_pc=%h cycles=%0d timeout=%b expected 0/0/0/0",
                     bus.flush, bus.new_pc, bus.stall_cycles, bus.stall_timeout);
        end
    endtask

    task automatic test_single_stall();
        bus.stallreq = 6'b000100;
        #1;
        tests_run++;
        if (bus.stall !== 6'b000111) begin
            tests_failed++;
            $display("[TB] FAIL single_stall_mask: got %b expected 000111", bus.stall);
        end
        next_cycle();
        bus.stallreq = '0;
        #1;
        tests_run++;
        if (bus.stall !== 6'b000000 || bus.stall_cycles !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_stall_after: got stall=%b cycles=%0d expected 000000/1",
                     bus.stall, bus.stall_cycles);
        end
    endtask

    task automatic test_held_stall();
        int bad;
        bus.clr_cnt = 1'b1;
        next_cycle();
        bus.clr_cnt = 1'b0;
        bus.stallreq = 6'b001100;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.stall !== 6'b001111) bad++;
            next_cycle();
        end
        bus.stallreq = '0;
        #1;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL held_stall_mask: got %0d wrong cycles expected 0 (last stall=%b)", bad, bus.stall);
        end
        tests_run++;
        if (bus.stall_cycles !== 32'd5 || bus.stall_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL held_stall_count: got cycles=%0d timeout=%b expected 5/0",
                     bus.stall_cycles, bus.stall_timeout);
        end
    endtask

    task automatic test_exception();
        bus.excp_req = 1'b1;
        bus.excp_pc = 32'hBFC00380;
        bus.stallreq = 6'b000100;
        #1;
        tests_run++;
        if (bus.stall !== 6'b000111 || bus.flush !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL excp_cycle_n: got stall=%b flush=%b expected 000111/0", bus.stall, bus.flush);
        end
        next_cycle();
        bus.excp_req = 1'b0;
        bus.excp_pc = 32'h0;
        #1;
        tests_run++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'hBFC00380 || bus.stall !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL excp_cycle_n1: got flush=%b new_pc=%h stall=%b expected 1/bfc00380/000000",
                     bus.flush, bus.new_pc, bus.stall);
        end
        next_cycle();
        bus.stallreq = '0;
        #1;
        tests_run++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'hBFC00380) begin
            tests_failed++;
            $display("[TB] FAIL excp_cycle_n2: got flush=%b new_pc=%h expected 0/bfc00380", bus.flush, bus.new_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic        excp_vec  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] pc_vec    [6] = '{32'h1000_0000, 32'h2000_0000, 32'h0, 32'h3000_0000, 32'h0, 32'h0};
        logic        flush_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] pc_exp    [6] = '{32'hBFC00380, 32'h1000_0000, 32'h1000_0000,
                                       32'h1000_0000, 32'h3000_0000, 32'h3000_0000};
        for (int i = 0; i < 6; i++) begin
            bus.excp_req = excp_vec[i];
            bus.excp_pc = pc_vec[i];
            #1;
            tests_run++;
            if (bus.flush !== flush_exp[i] || bus.new_pc !== pc_exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back[%0d]: got flush=%b new_pc=%h expected %b/%h",
                         i, bus.flush, bus.new_pc, flush_exp[i], pc_exp[i]);
            end
            next_cycle();
        end
        bus.excp_req = 1'b0;
    endtask

    task automatic test_watchdog();
        bus.clr_cnt = 1'b1;
        next_cycle();
        bus.clr_cnt = 1'b0;
        bus.stallreq = 6'b001000;
        repeat (63) next_cycle();
        tests_run++;
        if (bus.stall_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wd_first_run_63: got timeout=%b expected 0", bus.stall_timeout);
        end
        bus.stallreq = '0;
        next_cycle();
        bus.stallreq = 6'b001000;
        repeat (63) next_cycle();
        tests_run++;
        if (bus.stall_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wd_second_run_63: got timeout=%b expected 0", bus.stall_timeout);
        end
        next_cycle();
        tests_run++;
        if (bus.stall_timeout !== 1'b1 || bus.stall_cycles !== 32'd127) begin
            tests_failed++;
            $display("[TB] FAIL wd_second_run_64: got timeout=%b cycles=%0d expected 1/127",
                     bus.stall_timeout, bus.stall_cycles);
        end
        bus.stallreq = '0;
        repeat (3) next_cycle();
        tests_run++;
        if (bus.stall_timeout !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wd_sticky: got timeout=%b expected 1", bus.stall_timeout);
        end
        bus.clr_cnt = 1'b1;
        next_cycle();
        bus.clr_cnt = 1'b0;
        tests_run++;
        if (bus.stall_timeout !== 1'b0 || bus.stall_cycles !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL wd_clear: got timeout=%b cycles=%0d expected 0/0",
                     bus.stall_timeout, bus.stall_cycles);
        end
    endtask

    task automatic test_reset_mid_flush();
        bus.excp_req = 1'b1;
        bus.excp_pc = 32'h8000_0180;
        next_cycle();
        bus.stallreq = 6'b000100;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.flush !== 1'b1 || bus.stall !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL mid_flush_entry: got flush=%b stall=%b expected 1/000000", bus.flush, bus.stall);
        end
        next_cycle();
        rst = 1'b0;
        bus.excp_req = 1'b0;
        bus.stallreq = '0;
        #1;
        tests_run++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_flush_reset: got flush=%b new_pc=%h expected 0/00000000", bus.flush, bus.new_pc);
        end
        next_cycle();
        tests_run++;
        if (bus.flush !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_flush_no_pending: got flush=%b expected 0", bus.flush);
        end
    endtask

    task automatic test_saturate();
        bus_s.stallreq = 6'b100000;
        repeat (14) next_cycle();
        tests_run++;
        if (bus_s.stall_cycles !== 4'd14) begin
            tests_failed++;
            $display("[TB] FAIL sat_count_14: got %0d expected 14", bus_s.stall_cycles);
        end
        repeat (6) next_cycle();
        bus_s.stallreq = '0;
        tests_run++;
        if (bus_s.stall_cycles !== 4'd15) begin
            tests_failed++;
            $display("[TB] FAIL sat_count_20: got %0d expected 15", bus_s.stall_cycles);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] time limit exceeded");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        #1;
        test_reset();
        test_single_stall();
        test_held_stall();
        test_exception();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_flush();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
